// File: rtl/arb_pkg.sv
// Shared constants and the word record carried from the packer into its output FIFO.
package arb_pkg;

  localparam int ARB_DATA_W         = 8;
  localparam int ARB_BYTES_PER_WORD = 4;
  localparam int ARB_OUT_W          = ARB_DATA_W * ARB_BYTES_PER_WORD;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  count;
  } packed_word_t;

endpackage

// File: rtl/arbiter_byte_packer_sync_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; a push into a full FIFO
// is accepted only when a pop retires the head on the same edge.
module sync_fifo
  import arb_pkg::*;
#(
  parameter int WIDTH = $bits(packed_word_t),
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head reads as zero when nothing is queued, so stale entries never show.
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/arbiter_byte_packer.sv
// Packs the arbiter byte stream into 32-bit words, queues them in a FWFT FIFO,
// and counts words lost when the queue cannot take them (input never stalls).
module arbiter_byte_packer
  import arb_pkg::*;
#(
  parameter  int DATA_W         = ARB_DATA_W,
  parameter  int BYTES_PER_WORD = ARB_BYTES_PER_WORD,
  parameter  int FIFO_DEPTH     = 4,
  localparam int OUT_W          = DATA_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              flush,
  output logic [OUT_W-1:0]  out_data,
  output logic [2:0]        out_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int FILL_W = $clog2(BYTES_PER_WORD);

  logic [FILL_W-1:0] fill;
  logic [OUT_W-1:0]  asm_word;
  logic [OUT_W-1:0]  word_next;
  logic [2:0]        count_next;
  logic              push_req;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  packed_word_t      push_pkt;
  packed_word_t      head_pkt;

  // The byte accepted this edge is merged in before the push decision so a
  // flush or completion carries it.
  always_comb begin
    word_next = asm_word;
    if (din_valid) begin
      word_next[fill*DATA_W +: DATA_W] = din;
    end
  end

  assign count_next = 3'(fill) + 3'(din_valid);
  assign push_req   = (din_valid && (fill == FILL_W'(BYTES_PER_WORD-1))) ||
                      (flush && ((fill != '0) || din_valid));
  assign drop       = push_req && fifo_full && !(out_ready && !fifo_empty);

  assign push_pkt.data  = word_next;
  assign push_pkt.count = count_next;

  sync_fifo #(
    .WIDTH ($bits(packed_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_pkt),
    .pop       (out_ready),
    .head      (head_pkt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_pkt.data;
  assign out_count = head_pkt.count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill     <= '0;
      asm_word <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_req) begin
        fill     <= '0;
        asm_word <= '0;
      end else if (din_valid) begin
        fill     <= fill + FILL_W'(1);
        asm_word <= word_next;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbiter_byte_packer.sv
// Scoreboard bench for arbiter_byte_packer: a byte-level model predicts each
// word, a negedge monitor compares words as the consumer pops them.
module tb_arbiter_byte_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        overflow;
  logic [7:0]  drop_cnt;

  logic [34:0] sb[$];
  logic [34:0] exp_w;
  logic [31:0] m_word = '0;
  int          m_fill = 0;
  int          checks = 0;
  int          passed = 0;

  arbiter_byte_packer dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are stable across the negedge, so a handshake seen here is the pop
  // the next rising edge performs.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_word: got data=%h count=%0d, expected no word", out_data, out_count);
      end else begin
        exp_w = sb.pop_front();
        if ({out_data, out_count} !== exp_w)
          $display("FAIL word_order: got data=%h count=%0d, expected data=%h count=%0d",
                   out_data, out_count, exp_w[34:3], exp_w[2:0]);
        else
          passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic v, input logic f, input logic keep);
    din = b;
    din_valid = v;
    flush = f;
    if (v) begin
      m_word[8*m_fill +: 8] = b;
      m_fill++;
    end
    if (m_fill == 4 || (f && m_fill > 0)) begin
      if (keep) sb.push_back({m_word, 3'(m_fill)});
      m_word = '0;
      m_fill = 0;
    end
    step();
    din_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 8'hEE;
    din_valid = 1'b1;
    flush = 1'b1;
    step();
    step();
    rst = 1'b0;
    din_valid = 1'b0;
    flush = 1'b0;
    sb.delete();
    m_word = '0;
    m_fill = 0;
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) $display("FAIL drain_timeout: %0d words still expected, expected 0", sb.size());
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL drain_empty: out_valid=%b, expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_data, out_count, overflow, drop_cnt} !== 45'd0)
      $display("FAIL reset_outputs: valid=%b data=%h count=%0d ovf=%b drops=%0d, expected all 0",
               out_valid, out_data, out_count, overflow, drop_cnt);
    else passed++;
    checks++;
    if (dut.fill !== 2'd0) $display("FAIL reset_fill: fill=%0d, expected 0", dut.fill);
    else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(8'd10, 1, 0, 1);
    send(8'd20, 1, 0, 1);
    send(8'd30, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: out_valid=%b, expected 0", out_valid);
    else passed++;
    send(8'd40, 1, 0, 1);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h281E140A, 3'd4})
      $display("FAIL basic_word: valid=%b data=%h count=%0d, expected 1 281e140a 4",
               out_valid, out_data, out_count);
    else passed++;
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(8'd87, 1, 0, 1);
    send(8'd56, 1, 0, 1);
    send(8'd0, 0, 1, 1);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h00003857, 3'd2})
      $display("FAIL flush_partial: valid=%b data=%h count=%0d, expected 1 00003857 2",
               out_valid, out_data, out_count);
    else passed++;
    send(8'hAB, 1, 0, 1);
    send(8'd0, 0, 1, 1);
    send(8'h01, 1, 0, 1);
    send(8'h02, 1, 0, 1);
    send(8'h03, 1, 1, 1);
    wait_drain();
    send(8'h04, 1, 0, 1);
    send(8'h05, 1, 0, 1);
    send(8'h06, 1, 0, 1);
    send(8'h07, 1, 1, 1);
    send(8'd0, 0, 1, 1);
    wait_drain();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_idle_noop: out_valid=%b, expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(8'(i + 1), 1, 0, (i < 16));
    checks++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd1})
      $display("FAIL overflow_first_drop: ovf=%b drops=%0d, expected 1 1", overflow, drop_cnt);
    else passed++;
    checks++;
    if ({out_data, out_count} !== {32'h04030201, 3'd4})
      $display("FAIL overflow_head_held: data=%h count=%0d, expected 04030201 4", out_data, out_count);
    else passed++;
    wait_drain();
  endtask

  task automatic test_full_pop_same_edge();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) send(8'(8'h40 + i), 1, 0, 1);
    out_ready = 1'b1;
    send(8'h53, 1, 0, 1);
    out_ready = 1'b0;
    checks++;
    if ({overflow, drop_cnt} !== 9'd0)
      $display("FAIL full_pop_no_drop: ovf=%b drops=%0d, expected 0 0", overflow, drop_cnt);
    else passed++;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h47464544})
      $display("FAIL full_pop_head: valid=%b data=%h, expected 1 47464544", out_valid, out_data);
    else passed++;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'h60 + i), 1, 0, 1);
    rst = 1'b1;
    din = 8'hEE;
    din_valid = 1'b1;
    step();
    rst = 1'b0;
    din_valid = 1'b0;
    sb.delete();
    m_word = '0;
    m_fill = 0;
    checks++;
    if ({out_valid, dut.fill} !== 3'd0)
      $display("FAIL reset_mid_state: valid=%b fill=%0d, expected 0 0", out_valid, dut.fill);
    else passed++;
    out_ready = 1'b1;
    send(8'h11, 1, 0, 1);
    send(8'h12, 1, 0, 1);
    send(8'h13, 1, 0, 1);
    send(8'h14, 1, 0, 1);
    checks++;
    if ({out_data, out_count} !== {32'h14131211, 3'd4})
      $display("FAIL reset_mid_clean_word: data=%h count=%0d, expected 14131211 4", out_data, out_count);
    else passed++;
    wait_drain();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), 1, 0, 1);
    for (int i = 0; i < 254; i++) send(8'(i), 1, 1, 0);
    checks++;
    if (drop_cnt !== 8'd254) $display("FAIL sat_254: drops=%0d, expected 254", drop_cnt);
    else passed++;
    send(8'h55, 1, 1, 0);
    checks++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd255})
      $display("FAIL sat_255: ovf=%b drops=%0d, expected 1 255", overflow, drop_cnt);
    else passed++;
    for (int i = 0; i < 45; i++) send(8'(i), 1, 1, 0);
    checks++;
    if ({overflow, drop_cnt, out_data} !== {1'b1, 8'd255, 32'h03020100})
      $display("FAIL sat_hold: ovf=%b drops=%0d head=%h, expected 1 255 03020100", overflow, drop_cnt, out_data);
    else passed++;
    do_reset();
    checks++;
    if ({overflow, drop_cnt, out_valid} !== 10'd0)
      $display("FAIL sat_reset_clear: ovf=%b drops=%0d valid=%b, expected 0 0 0", overflow, drop_cnt, out_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_overflow();
    test_full_pop_same_edge();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/arbiter_byte_packer.md
# arbiter_byte_packer

Downstream stage of the round-robin FIFO arbiter: consumes the arbiter's 8-bit `dout`/`valid` byte stream and packs consecutive bytes into 32-bit words. Completed words go into a small output FIFO and are presented on a ready/valid interface to the next consumer. The arbiter has no backpressure, so the packer never stalls its input; it drops words and counts them when its output FIFO overflows.

## Interface
Parameters:
- `DATA_W`, 8, input byte width.
- `BYTES_PER_WORD`, 4, bytes packed per output word; `OUT_W = DATA_W*BYTES_PER_WORD` = 32.
- `FIFO_DEPTH`, 4, output FIFO depth in words; must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  `DATA_W`  byte from arbiter `dout`.
- `din_valid`  in  1  byte qualifier from arbiter `valid`.
- `flush`  in  1  emit a partially filled word.
- `out_data`  out  `OUT_W`  head word; first received byte in bits [7:0].
- `out_count`  out  3  valid bytes in head word, 1..4.
- `out_valid`  out  1  head word valid.
- `out_ready`  in  1  consumer accepts the head word.
- `overflow`  out  1  sticky; set on the first dropped word.
- `drop_cnt`  out  8  dropped words; saturates at 255.

## Operation
- Pack counter `fill` counts 0..BYTES_PER_WORD-1. Accepted bytes collect in a shift/assembly register.
- Byte with index `fill` goes to bits [8*fill+7 : 8*fill].
- `din_valid`=1 accepts `din` unconditionally on every edge.
- On the edge that accepts the byte at `fill`=3, the word is complete:
  - If the FIFO has space, it pushes {word, count=4}.
  - `fill` wraps to 0.
  - Unused assembly bytes are cleared to 0.
- `flush`=1 with `fill`>0 or `din_valid`=1:
  - Pushes the current partial word, including any byte accepted that same edge.
  - `count` = bytes held; upper bytes are zero.
  - `fill` goes to 0.
- `flush` with `fill`=0 and `din_valid`=0 is a no-op.
- `flush` on the same edge that completes a 4-byte word produces exactly one word, with count 4.
- A push succeeds if the FIFO is not full, or if it is full and a pop happens on the same edge.
- A failed push drops the word, sets `overflow`, and increments `drop_cnt` (saturating). Packing continues with `fill`=0.
- Pop occurs when `out_valid && out_ready`. `out_ready` while empty has no effect.
- `overflow` and `drop_cnt` clear only on `rst`.

## Timing
- Reset values (first edge with `rst`=1):
  - `out_valid`=0, `out_data`=0, `out_count`=0.
  - `overflow`=0, `drop_cnt`=0, `fill`=0.
  - FIFO empty; assembly register 0.
  - Inputs are ignored during reset.
- Reset mid-word discards the partial word and all FIFO contents; no word is emitted.
- Latency: `out_valid` rises 1 cycle after the edge that accepts the completing byte (or the flush), when the FIFO was empty.
- FIFO is first-word fall-through: `out_data`/`out_count` are registered, stable while `out_valid && !out_ready`.
- Throughput: one byte per cycle sustained in; one word per cycle out.
- Pointers are `$clog2(FIFO_DEPTH)`+1 bits wide, with the wrap bit used to distinguish full from empty.

## Structure
- Package `arb_pkg`:
  - `ARB_DATA_W`=8, `ARB_BYTES_PER_WORD`=4.
  - `typedef struct packed {logic [31:0] data; logic [2:0] count;} packed_word_t`.
- Sub-module `sync_fifo`:
  - Parameterised width and depth; FWFT.
  - Exposes `push`, `pop`, `full`, `empty`.
  - Stores `packed_word_t`.
- Top level holds the pack counter, assembly register, flush logic, and the overflow/drop counters.

## Test plan
- Bytes 10, 20, 30, 40 on consecutive cycles, `out_ready`=1 → one word `0x281E140A`, count 4, `out_valid` high 1 cycle after byte 40.
- Bytes 87, 56, then `flush` → word `0x00003857`, count 2. A subsequent byte starts a new word at bits [7:0].
- `out_ready`=0, 20 bytes (5 words) → first 4 words held in order, 5th dropped, `overflow`=1, `drop_cnt`=1. Drain returns words 1–4 unchanged.
- FIFO full, completing byte and pop on the same edge → no drop, `drop_cnt` stays 0, new word appears last.
- `rst` asserted after 2 bytes and with 2 words queued → next cycle `out_valid`=0, `fill`=0. The next 4 bytes form a clean word.
- Inject 300 drops → `drop_cnt` saturates at 255, `overflow` stays 1 until `rst`.
